// File: rtl/matrix_scalar_mul_sched.sv
// Round-robin scheduler for two requesters sharing one element multiplier.
// Scales a packed DIM x DIM matrix by a 4-bit scalar, one element per clock.
module matrix_scalar_mul_sched #(
   parameter int ELEM_W = 8,
   parameter int DIM    = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req0_valid,
   input  logic [2:0]                req0_m,
   input  logic [2:0]                req0_n,
   input  logic [3:0]                req0_scalar,
   input  logic [DIM*DIM*ELEM_W-1:0] req0_matrix,
   output logic                      req0_ready,
   input  logic                      req1_valid,
   input  logic [2:0]                req1_m,
   input  logic [2:0]                req1_n,
   input  logic [3:0]                req1_scalar,
   input  logic [DIM*DIM*ELEM_W-1:0] req1_matrix,
   output logic                      req1_ready,
   output logic [DIM*DIM*ELEM_W-1:0] res_matrix,
   output logic [2:0]                res_m,
   output logic [2:0]                res_n,
   output logic                      res_owner,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      err,
   output logic                      busy
);

   // state | meaning
   // IDLE  | arbitrate between requesters, accept one job
   // CALC  | write one scaled element per clock, row-major
   // DONE  | hold result with res_valid until res_ready
   // ERR   | one-cycle err pulse for a job with bad dimensions

   localparam int MW = DIM * DIM * ELEM_W;
   localparam int IW = $clog2(MW);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_ERR} state_t;

   state_t              state;
   logic                last;
   logic [2:0]          row_cnt;
   logic [2:0]          col_cnt;
   logic [3:0]          op_scalar;
   logic [MW-1:0]       op_matrix;

   logic                grant_vld;
   logic                grant_idx;
   logic                accept;
   logic [2:0]          acc_m;
   logic [2:0]          acc_n;
   logic                dims_ok;
   logic [IW-1:0]       elem_base;
   logic [ELEM_W-1:0]   prod;

   // On contention the requester that did not win last time is granted.
   always_comb begin
      grant_vld = req0_valid | req1_valid;
      grant_idx = 1'b0;
      if (req0_valid && req1_valid)
         grant_idx = ~last;
      else if (req1_valid)
         grant_idx = 1'b1;
   end

   assign req0_ready = (state == S_IDLE) && grant_vld && !grant_idx;
   assign req1_ready = (state == S_IDLE) && grant_vld && grant_idx;
   assign accept     = req0_ready | req1_ready;

   assign acc_m   = grant_idx ? req1_m : req0_m;
   assign acc_n   = grant_idx ? req1_n : req0_n;
   assign dims_ok = (acc_m != 3'd0) && (acc_m <= 3'(DIM)) &&
                    (acc_n != 3'd0) && (acc_n <= 3'(DIM));

   assign elem_base = IW'((int'(row_cnt) * DIM + int'(col_cnt)) * ELEM_W);
   // Only the low byte of the 12-bit product is kept, so an 8-bit multiply suffices.
   assign prod = op_matrix[elem_base +: ELEM_W] * ELEM_W'(op_scalar);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         last       <= 1'b1;
         row_cnt    <= '0;
         col_cnt    <= '0;
         op_scalar  <= '0;
         op_matrix  <= '0;
         res_matrix <= '0;
         res_m      <= '0;
         res_n      <= '0;
         res_owner  <= 1'b0;
         res_valid  <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_scalar  <= grant_idx ? req1_scalar : req0_scalar;
                  op_matrix  <= grant_idx ? req1_matrix : req0_matrix;
                  res_m      <= acc_m;
                  res_n      <= acc_n;
                  res_owner  <= grant_idx;
                  last       <= grant_idx;
                  res_matrix <= '0;
                  row_cnt    <= '0;
                  col_cnt    <= '0;
                  busy       <= 1'b1;
                  if (dims_ok) begin
                     state <= S_CALC;
                  end else begin
                     state <= S_ERR;
                     err   <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               res_matrix[elem_base +: ELEM_W] <= prod;
               if (col_cnt == res_n - 3'd1) begin
                  col_cnt <= '0;
                  if (row_cnt == res_m - 3'd1) begin
                     state     <= S_DONE;
                     res_valid <= 1'b1;
                  end else begin
                     row_cnt <= row_cnt + 3'd1;
                  end
               end else begin
                  col_cnt <= col_cnt + 3'd1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  state     <= S_IDLE;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            S_ERR: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
